bitvert_column_sequencer: RTL
=============================

Name: bitvert_column_sequencer

Overview:
- Upstream control stage for the 16-lane bit-vertical MAC.
- Accepts one activation tile (16 signed activations) and a stream of per-weight-bit-column descriptors.
- Precomputes the two 8-lane group activation sums and registers every MAC input, one column per cycle.
- Appends one drain column per tile so the MAC's delayed partial-sum register is zeroed, then signals tile completion once MAC latency has elapsed.

Parameters:
DATA_WIDTH, 8, activation width
VEC_LENGTH, 16, activations per tile (fixed structure: 2 groups of 8, 8 mux lanes)
SUM_ACT_WIDTH, $clog2(VEC_LENGTH)+DATA_WIDTH-1, group-sum width (11)
MAC_LATENCY, 2, cycles from last MAC enable until the MAC result is stable

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
act_valid  in  1  activation tile offered
act_ready  out  1  tile accepted when act_valid&act_ready
act_data  in  [VEC_LENGTH] x DATA_WIDTH signed  tile activations
act_first  in  1  tile starts a new output: first column loads accum_prev
col_valid  in  1  column descriptor offered
col_ready  out  1  descriptor accepted when col_valid&col_ready
col_sel  in  [VEC_LENGTH/2] x 3  mux selects
col_val  in  [VEC_LENGTH/2] x 1  mux lane valids
col_skip_zero  in  [VEC_LENGTH/8] x 1  per-group skip-zero flags
col_mul_const  in  3 signed  constant multiplier
col_shift_mul  in  1  shift constant product by 3
col_en_mul  in  1  enable constant multiplier
col_idx  in  3  bit position of column (7 = MSB)
col_last  in  1  last column of tile
mac_act  out  [VEC_LENGTH] x DATA_WIDTH signed  activations to MAC
mac_act_sel  out  [VEC_LENGTH/2] x 3  mux selects
mac_act_val  out  [VEC_LENGTH/2] x 1  mux lane valids
mac_sum_act  out  [VEC_LENGTH/8] x SUM_ACT_WIDTH signed  group sums
mac_mul_const  out  3 signed  constant multiplier
mac_is_shift_mul  out  1  shift constant product by 3
mac_en_mul  out  1  enable constant multiplier
mac_column_idx  out  3  column bit position
mac_is_msb  out  1  column is MSB
mac_is_skip_zero  out  [VEC_LENGTH/8] x 1  skip-zero flags
mac_en_acc  out  1  MAC accumulate enable
mac_load_accum  out  1  MAC loads accum_prev this column
tile_done  out  1  one-cycle pulse: MAC result valid
busy  out  1  state != IDLE

Behaviour:
- FSM states:
  - IDLE: act_ready=1; on tile accept, capture act_data and act_first, go to SUM.
  - SUM: one cycle. Register mac_sum_act[g] = sign-extended sum of act[8g..8g+7]; drive mac_act from the capture. Go to RUN.
  - RUN: col_ready=1; each accepted descriptor is registered onto mac_* next cycle with mac_en_acc=1. On col_last accept, go to DRAIN.
  - DRAIN: one cycle. Drive mac_en_acc=1, mac_en_mul=0, all mac_act_val=0, all mac_is_skip_zero=1, mac_load_accum=0. Go to WAIT.
  - WAIT: count MAC_LATENCY cycles, then pulse tile_done, go to IDLE.
- Column register fields: mac_is_msb = (col_idx==7).
- mac_load_accum=1 only on the first issued column of a tile with act_first=1; 0 otherwise, including non-first tiles.
- RUN with col_valid=0: bubble. mac_en_acc=0 and mac_load_accum=0; other mac_* fields hold.
- Column order is arbitrary and columns may be skipped; a tile has ≥1 column.
- Group sums are exact: 8 × -128 = -1024 is the minimum, 8 × 127 = 1016 the maximum; no saturation.
- mac_act and mac_sum_act hold for the whole tile, until the next tile's SUM.
- Reset, asynchronous at any state: IDLE; every output register 0; act_ready=1, col_ready=0, tile_done=0, busy=0. An in-flight tile is discarded.
- Simultaneous events: act_valid is ignored outside IDLE. col_valid is ignored outside RUN.
- Descriptor latency: accept at cycle t → mac_* valid at t+1.

Decomposition:
- Shared package:
  - FSM state enum {IDLE, SUM, RUN, DRAIN, WAIT}.
  - Column-descriptor packed struct (sel, val, skip_zero, mul_const, shift_mul, en_mul, idx, last).
  - Constants MSB_COL=7 and GROUP_SIZE=8.
- Sub-module: bitvert_group_sum (combinational signed adder tree, 8 inputs → SUM_ACT_WIDTH).

Test Plan:
- Reset mid-RUN after 3 columns → next cycle: IDLE, mac_en_acc=0, col_ready=0, act_ready=1, busy=0.
- Tile of all -128, act_first=1 → mac_sum_act = {-1024, -1024}. Tile of all 127 → {1016, 1016}.
- act_first=1; columns idx 0,3,7 back-to-back, col_last on 7:
  - mac_load_accum=1 only with idx 0; mac_is_msb=1 only with idx 7.
  - DRAIN cycle follows, with val=0, skip_zero=1, en_mul=0.
  - tile_done pulses 1+MAC_LATENCY cycles after the DRAIN cycle.
- col_valid low 2 cycles between columns 1 and 2 → two cycles with mac_en_acc=0 and fields held; column count unaffected.
- act_first=0 tile → mac_load_accum never asserted.
- act_valid held high through RUN/DRAIN/WAIT → no second tile capture until the cycle after the tile_done pulse; act_ready=1 only in IDLE.
- End-to-end with the MAC model: act 1..16, 8 columns matching weight 0x5A in all lanes → final MAC accumulator equals Σ act·weight.

Source files
------------

// File: rtl/bitvert_column_sequencer_pkg.sv
// Shared types and constants for the bit-vertical column sequencer.
// The group/mux structure is fixed: 16 activations as 2 groups of 8, 8 mux lanes.
package bitvert_column_sequencer_pkg;

  localparam int unsigned GROUP_SIZE = 8;
  localparam int unsigned NUM_GROUPS = 2;
  localparam int unsigned MUX_LANES  = 8;
  localparam logic [2:0]  MSB_COL    = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StSum,
    StRun,
    StDrain,
    StWait
  } seq_state_e;

  typedef struct packed {
    logic [MUX_LANES-1:0][2:0] sel;
    logic [MUX_LANES-1:0]      val;
    logic [NUM_GROUPS-1:0]     skip_zero;
    logic [2:0]                mul_const;
    logic                      shift_mul;
    logic                      en_mul;
    logic [2:0]                idx;
    logic                      last;
  } col_desc_t;

  function automatic logic is_msb_col(input logic [2:0] idx);
    return idx == MSB_COL;
  endfunction

endpackage

// File: rtl/bitvert_group_sum.sv
// Combinational signed adder tree: sum of one 8-lane activation group.
// Each level widens by one bit so the result is exact (no saturation).
module bitvert_group_sum
  import bitvert_column_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned SUM_ACT_WIDTH = DATA_WIDTH + 3
) (
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0] act,
  output logic [SUM_ACT_WIDTH-1:0]         sum
);

  logic signed [DATA_WIDTH-1:0] lane [GROUP_SIZE];
  logic signed [DATA_WIDTH:0]   s1   [4];
  logic signed [DATA_WIDTH+1:0] s2   [2];
  logic signed [DATA_WIDTH+2:0] s3;

  always_comb begin
    for (int i = 0; i < int'(GROUP_SIZE); i++) begin
      lane[i] = act[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int i = 0; i < 4; i++) begin
      s1[i] = {lane[2*i][DATA_WIDTH-1], lane[2*i]} + {lane[2*i+1][DATA_WIDTH-1], lane[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      s2[i] = {s1[2*i][DATA_WIDTH], s1[2*i]} + {s1[2*i+1][DATA_WIDTH], s1[2*i+1]};
    end
    s3 = {s2[0][DATA_WIDTH+1], s2[0]} + {s2[1][DATA_WIDTH+1], s2[1]};
  end

  assign sum = SUM_ACT_WIDTH'(s3);

endmodule

// File: rtl/bitvert_column_sequencer.sv
// Upstream control for the 16-lane bit-vertical MAC: captures a tile, precomputes
// group sums, issues one registered column per cycle, then a drain column and tile_done.
module bitvert_column_sequencer
  import bitvert_column_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned VEC_LENGTH    = 16,
  parameter int unsigned SUM_ACT_WIDTH = $clog2(VEC_LENGTH) + DATA_WIDTH - 1,
  parameter int unsigned MAC_LATENCY   = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 act_valid,
  output logic                                 act_ready,
  input  logic [VEC_LENGTH*DATA_WIDTH-1:0]     act_data,
  input  logic                                 act_first,
  input  logic                                 col_valid,
  output logic                                 col_ready,
  input  logic [VEC_LENGTH/2*3-1:0]            col_sel,
  input  logic [VEC_LENGTH/2-1:0]              col_val,
  input  logic [VEC_LENGTH/8-1:0]              col_skip_zero,
  input  logic [2:0]                           col_mul_const,
  input  logic                                 col_shift_mul,
  input  logic                                 col_en_mul,
  input  logic [2:0]                           col_idx,
  input  logic                                 col_last,
  output logic [VEC_LENGTH*DATA_WIDTH-1:0]     mac_act,
  output logic [VEC_LENGTH/2*3-1:0]            mac_act_sel,
  output logic [VEC_LENGTH/2-1:0]              mac_act_val,
  output logic [VEC_LENGTH/8*SUM_ACT_WIDTH-1:0] mac_sum_act,
  output logic [2:0]                           mac_mul_const,
  output logic                                 mac_is_shift_mul,
  output logic                                 mac_en_mul,
  output logic [2:0]                           mac_column_idx,
  output logic                                 mac_is_msb,
  output logic [VEC_LENGTH/8-1:0]              mac_is_skip_zero,
  output logic                                 mac_en_acc,
  output logic                                 mac_load_accum,
  output logic                                 tile_done,
  output logic                                 busy
);

  localparam int unsigned ActW = VEC_LENGTH * DATA_WIDTH;
  localparam int unsigned SumW = NUM_GROUPS * SUM_ACT_WIDTH;
  localparam int unsigned SelW = MUX_LANES * 3;
  localparam int unsigned CntW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

  seq_state_e state_q, state_d;

  logic [ActW-1:0]       act_q, act_d;
  logic                  act_first_q, act_first_d;
  logic                  first_pend_q, first_pend_d;
  logic [CntW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [ActW-1:0]       mac_act_q, mac_act_d;
  logic [SumW-1:0]       sum_q, sum_d;
  logic [SelW-1:0]       sel_q, sel_d;
  logic [MUX_LANES-1:0]  val_q, val_d;
  logic [NUM_GROUPS-1:0] skip_q, skip_d;
  logic [2:0]            mul_const_q, mul_const_d;
  logic                  shift_q, shift_d;
  logic                  en_mul_q, en_mul_d;
  logic [2:0]            idx_q, idx_d;
  logic                  msb_q, msb_d;
  logic                  en_acc_q, en_acc_d;
  logic                  load_q, load_d;
  logic                  tile_done_q, tile_done_d;

  col_desc_t       col_in;
  logic [SumW-1:0] group_sum;

  assign col_in = {col_sel, col_val, col_skip_zero, col_mul_const, col_shift_mul, col_en_mul,
                   col_idx, col_last};

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
    bitvert_group_sum #(
      .DATA_WIDTH    (DATA_WIDTH),
      .SUM_ACT_WIDTH (SUM_ACT_WIDTH)
    ) u_group_sum (
      .act (act_q[g*GROUP_SIZE*DATA_WIDTH +: GROUP_SIZE*DATA_WIDTH]),
      .sum (group_sum[g*SUM_ACT_WIDTH +: SUM_ACT_WIDTH])
    );
  end

  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    act_first_d  = act_first_q;
    first_pend_d = first_pend_q;
    wait_cnt_d   = wait_cnt_q;
    mac_act_d    = mac_act_q;
    sum_d        = sum_q;
    sel_d        = sel_q;
    val_d        = val_q;
    skip_d       = skip_q;
    mul_const_d  = mul_const_q;
    shift_d      = shift_q;
    en_mul_d     = en_mul_q;
    idx_d        = idx_q;
    msb_d        = msb_q;
    en_acc_d     = 1'b0;
    load_d       = 1'b0;
    tile_done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (act_valid) begin
          act_d        = act_data;
          act_first_d  = act_first;
          first_pend_d = 1'b1;
          state_d      = StSum;
        end
      end
      StSum: begin
        mac_act_d = act_q;
        sum_d     = group_sum;
        state_d   = StRun;
      end
      StRun: begin
        // Without a descriptor this is a bubble: fields hold, enables stay low.
        if (col_valid) begin
          sel_d        = col_in.sel;
          val_d        = col_in.val;
          skip_d       = col_in.skip_zero;
          mul_const_d  = col_in.mul_const;
          shift_d      = col_in.shift_mul;
          en_mul_d     = col_in.en_mul;
          idx_d        = col_in.idx;
          msb_d        = is_msb_col(col_in.idx);
          en_acc_d     = 1'b1;
          load_d       = first_pend_q & act_first_q;
          first_pend_d = 1'b0;
          if (col_in.last) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Zero-contribution column that flushes the MAC's delayed partial sum.
        en_acc_d   = 1'b1;
        en_mul_d   = 1'b0;
        val_d      = '0;
        skip_d     = '1;
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (wait_cnt_q == CntW'(MAC_LATENCY - 1)) begin
          tile_done_d = 1'b1;
          state_d     = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      act_q        <= '0;
      act_first_q  <= 1'b0;
      first_pend_q <= 1'b0;
      wait_cnt_q   <= '0;
      mac_act_q    <= '0;
      sum_q        <= '0;
      sel_q        <= '0;
      val_q        <= '0;
      skip_q       <= '0;
      mul_const_q  <= '0;
      shift_q      <= 1'b0;
      en_mul_q     <= 1'b0;
      idx_q        <= '0;
      msb_q        <= 1'b0;
      en_acc_q     <= 1'b0;
      load_q       <= 1'b0;
      tile_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      act_first_q  <= act_first_d;
      first_pend_q <= first_pend_d;
      wait_cnt_q   <= wait_cnt_d;
      mac_act_q    <= mac_act_d;
      sum_q        <= sum_d;
      sel_q        <= sel_d;
      val_q        <= val_d;
      skip_q       <= skip_d;
      mul_const_q  <= mul_const_d;
      shift_q      <= shift_d;
      en_mul_q     <= en_mul_d;
      idx_q        <= idx_d;
      msb_q        <= msb_d;
      en_acc_q     <= en_acc_d;
      load_q       <= load_d;
      tile_done_q  <= tile_done_d;
    end
  end

  assign act_ready        = (state_q == StIdle);
  assign col_ready        = (state_q == StRun);
  assign busy             = (state_q != StIdle);
  assign mac_act          = mac_act_q;
  assign mac_sum_act      = sum_q;
  assign mac_act_sel      = sel_q;
  assign mac_act_val      = val_q;
  assign mac_mul_const    = mul_const_q;
  assign mac_is_shift_mul = shift_q;
  assign mac_en_mul       = en_mul_q;
  assign mac_column_idx   = idx_q;
  assign mac_is_msb       = msb_q;
  assign mac_is_skip_zero = skip_q;
  assign mac_en_acc       = en_acc_q;
  assign mac_load_accum   = load_q;
  assign tile_done        = tile_done_q;

endmodule
